ifid_stage: RTL and testbench
=============================

Name: ifid_stage

Overview:
- Pipeline register between instruction fetch (IF) and decode/issue (ID).
- Consumes the jump-stall and full-stall controls:
  - jump stall injects NOP bubbles, plus a programmable number of trailing bubbles after release;
  - full stall (ROB full) freezes the register contents.
- A committed jump from WB flushes the stage.
- Sole producer of the instruction/PC pair seen by ID.

Parameters:
- XLEN, 32, width of PC and instruction words (matches COMMON_WIDTH).
- NOP_INST, 32'h0000_0013, encoding driven on bubble cycles (addi x0,x0,0).
- POST_NOPS, 1, bubbles emitted after jump stall release or flush. Legal range 1..7; elaboration error outside it.

Ports:
- clk, input, 1, pipeline clock.
- rst_n, input, 1, asynchronous active-low reset.
- if_valid, input, 1, IF presents a fetched instruction this cycle.
- if_pc, input, XLEN, PC of the fetched instruction.
- if_inst, input, XLEN, fetched instruction word.
- jump_stall, input, 1, ID has detected a possible jump; level-held until WB resets it.
- full_stall, input, 1, ROB full; hold everything.
- jump_en, input, 1, WB committed a taken jump; IF redirects next cycle.
- id_valid, output, 1, registered instruction is real (0 = bubble).
- id_pc, output, XLEN, registered PC.
- id_inst, output, XLEN, registered instruction; NOP_INST on bubbles.
- id_bubble, output, 1, registered flag: this output is an injected bubble.

Behaviour:
- Reset values: id_valid=0, id_pc=0, id_inst=NOP_INST, id_bubble=1, state=RUN, cnt=0.
- Reset is async assert, sync deassert by clock. Asserting reset mid-stall or mid-drain discards all state immediately.
- "Bubble" means id_valid=0, id_pc=0, id_inst=NOP_INST, id_bubble=1.
- "Load" means id_valid=if_valid, id_pc=if_pc, id_inst=if_inst, id_bubble=0. If if_valid=0, a load still copies the inputs but sets id_inst=NOP_INST.
- "Hold" means outputs, state and cnt unchanged.
- Latency: exactly one cycle from IF inputs to ID outputs on a load.
- States: RUN, JSTALL, DRAIN. cnt is 3 bits.
- Per-edge priority, in order: jump_en, then full_stall, then jump_stall, then normal.
- jump_en=1 (any state, overrides full_stall):
  - bubble;
  - if POST_NOPS>1: cnt=POST_NOPS-1, go DRAIN;
  - else go RUN.
- full_stall=1 (no jump_en): hold in every state; cnt does not decrement.
- RUN:
  - jump_stall=1: bubble, go JSTALL;
  - else load.
- JSTALL:
  - jump_stall=1: bubble, stay;
  - jump_stall=0: bubble (release NOP, since IF data is stale), then cnt=POST_NOPS-1 and go DRAIN if nonzero, else go RUN.
- DRAIN:
  - jump_stall=1: bubble, go JSTALL;
  - else bubble, cnt-=1, go RUN when cnt reaches 0 on this edge.
- Total bubbles after release or flush are exactly POST_NOPS; the next edge in RUN loads.
- full_stall and jump_stall high together: hold; the JSTALL transition happens on the first edge after full_stall drops.

Optional Feature:
- Macro IFID_PERF_CNT_EN.
- When defined, adds outputs perf_bubble_cnt[31:0] and perf_hold_cnt[31:0]:
  - perf_bubble_cnt increments on every edge producing a bubble;
  - perf_hold_cnt increments on every full_stall hold edge;
  - both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package ifid_pkg holds:
  - ifid_state_e enum {RUN, JSTALL, DRAIN};
  - IFID_NOP constant;
  - a packed struct ifid_bus_t {valid, bubble, pc, inst}.
- One sub-module, ifid_ctrl: the FSM plus cnt, producing load/bubble/hold enables.
- ifid_stage instantiates ifid_ctrl and owns the data register.

Test Plan:
- Reset then stream: if_pc=0x100,0x104,0x108 with if_valid=1 -> id_pc=0x100,0x104,0x108 one cycle later each, id_bubble=0.
- jump_stall high for 3 edges then low, POST_NOPS=1 -> 4 bubbles with id_inst=0x13, then load of if_pc on the next edge.
- Repeat with POST_NOPS=3 -> 6 bubbles total (3 stall + release + 2 drain), then load.
- full_stall high for 2 edges while id_pc=0x200 -> id_pc stays 0x200, id_valid stays 1. Same stimulus during DRAIN -> cnt frozen and bubble count unchanged.
- jump_en during full_stall with id_pc=0x300 held -> next output is a bubble, then POST_NOPS-1 drain bubbles, then load.
- rst_n pulsed low asynchronously mid-JSTALL -> outputs reach reset values before the next clk edge. With IFID_PERF_CNT_EN defined, both counters read 0 and then match the bubble and hold counts of the scenarios above.

Source files
------------

// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
package ifid_pkg;

    localparam int unsigned IFID_XLEN = 32;

    // addi x0, x0, 0
    localparam logic [IFID_XLEN-1:0] IFID_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN,
        JSTALL,
        DRAIN
    } ifid_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 bubble;
        logic [IFID_XLEN-1:0] pc;
        logic [IFID_XLEN-1:0] inst;
    } ifid_bus_t;

    // Contents of the ID-side register on an injected bubble.
    function automatic ifid_bus_t ifid_bubble_bus(input logic [IFID_XLEN-1:0] nop);
        ifid_bus_t b;
        b.valid  = 1'b0;
        b.bubble = 1'b1;
        b.pc     = '0;
        b.inst   = nop;
        return b;
    endfunction

endpackage

// File: rtl/ifid_ctrl.sv
// IF/ID control FSM: decides per edge whether the data register loads,
// takes a bubble or holds, and counts trailing bubbles after a stall
// release or a flush.
module ifid_ctrl
    import ifid_pkg::*;
#(
    parameter int unsigned POST_NOPS = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic jump_stall_i,
    input  logic full_stall_i,
    input  logic jump_en_i,
    output logic load_o,
    output logic bubble_o,
    output logic hold_o
);

    if (POST_NOPS < 1 || POST_NOPS > 7) begin : g_bad_post_nops
        $error("ifid_ctrl: POST_NOPS must be in 1..7");
    end

    // Remaining drain bubbles once the release/flush bubble has been emitted.
    localparam logic [2:0] DrainInit = 3'(POST_NOPS - 1);

    ifid_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    // State and drain counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: flush beats full stall beats jump stall beats normal flow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (jump_en_i) begin
            cnt_d   = DrainInit;
            state_d = (DrainInit != 3'd0) ? DRAIN : RUN;
        end else if (full_stall_i) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (jump_stall_i) begin
                        state_d = JSTALL;
                    end
                end
                JSTALL: begin
                    if (!jump_stall_i) begin
                        cnt_d   = DrainInit;
                        state_d = (DrainInit != 3'd0) ? DRAIN : RUN;
                    end
                end
                DRAIN: begin
                    if (jump_stall_i) begin
                        state_d = JSTALL;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // Enables for the data register; exactly one is high every cycle.
    always_comb begin
        hold_o   = 1'b0;
        load_o   = 1'b0;
        bubble_o = 1'b0;
        if (jump_en_i) begin
            bubble_o = 1'b1;
        end else if (full_stall_i) begin
            hold_o = 1'b1;
        end else if (state_q == RUN && !jump_stall_i) begin
            load_o = 1'b1;
        end else begin
            bubble_o = 1'b1;
        end
    end

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register. Injects NOP bubbles on jump stalls and flushes,
// freezes on full (ROB) stalls. Optional performance counters are built
// when IFID_PERF_CNT_EN is defined.
module ifid_stage
    import ifid_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  NOP_INST  = IFID_NOP,
    parameter int unsigned      POST_NOPS = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            if_valid_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [XLEN-1:0] if_inst_i,
    input  logic            jump_stall_i,
    input  logic            full_stall_i,
    input  logic            jump_en_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_inst_o,
    output logic            id_bubble_o
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]     perf_bubble_cnt_o,
    output logic [31:0]     perf_hold_cnt_o
`endif
);

    if (XLEN != IFID_XLEN) begin : g_bad_xlen
        $error("ifid_stage: XLEN must match IFID_XLEN");
    end
    if (POST_NOPS < 1 || POST_NOPS > 7) begin : g_bad_post_nops
        $error("ifid_stage: POST_NOPS must be in 1..7");
    end

    logic load, bubble, hold;

    ifid_ctrl #(
        .POST_NOPS (POST_NOPS)
    ) u_ctrl (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .jump_stall_i (jump_stall_i),
        .full_stall_i (full_stall_i),
        .jump_en_i    (jump_en_i),
        .load_o       (load),
        .bubble_o     (bubble),
        .hold_o       (hold)
    );

    ifid_bus_t bus_q, bus_d;

    // Next register contents; an invalid fetch still loads but carries a NOP.
    always_comb begin
        bus_d = bus_q;
        if (bubble) begin
            bus_d = ifid_bubble_bus(NOP_INST);
        end else if (load) begin
            bus_d.valid  = if_valid_i;
            bus_d.bubble = 1'b0;
            bus_d.pc     = if_pc_i;
            bus_d.inst   = if_valid_i ? if_inst_i : NOP_INST;
        end
    end

    // ID-side data register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus_q <= ifid_bubble_bus(NOP_INST);
        end else begin
            bus_q <= bus_d;
        end
    end

    assign id_valid_o  = bus_q.valid;
    assign id_bubble_o = bus_q.bubble;
    assign id_pc_o     = bus_q.pc;
    assign id_inst_o   = bus_q.inst;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] perf_bubble_q, perf_bubble_d;
    logic [31:0] perf_hold_q, perf_hold_d;

    // Saturating event counters.
    always_comb begin
        perf_bubble_d = perf_bubble_q;
        perf_hold_d   = perf_hold_q;
        if (bubble && perf_bubble_q != 32'hFFFF_FFFF) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end
        if (hold && perf_hold_q != 32'hFFFF_FFFF) begin
            perf_hold_d = perf_hold_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_bubble_q <= 32'd0;
            perf_hold_q   <= 32'd0;
        end else begin
            perf_bubble_q <= perf_bubble_d;
            perf_hold_q   <= perf_hold_d;
        end
    end

    assign perf_bubble_cnt_o = perf_bubble_q;
    assign perf_hold_cnt_o   = perf_hold_q;
`endif

endmodule

// File: tb/tb_ifid_stage.sv
// Randomised self-checking bench for ifid_stage. Two instances run in
// parallel (POST_NOPS=1 and POST_NOPS=3) against a behavioural model that
// tracks "stalled" and "bubbles still owed".
module tb_ifid_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        jump_stall;
    logic        full_stall;
    logic        jump_en;

    logic        d_valid  [2];
    logic        d_bubble [2];
    logic [31:0] d_pc     [2];
    logic [31:0] d_inst   [2];
`ifdef IFID_PERF_CNT_EN
    logic [31:0] d_pbub   [2];
    logic [31:0] d_phold  [2];
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model state per instance.
    int          m_pend   [2];
    bit          m_stall  [2];
    logic        m_valid  [2];
    logic        m_bubble [2];
    logic [31:0] m_pc     [2];
    logic [31:0] m_inst   [2];
    int          m_pbub   [2];
    int          m_phold  [2];
    int          obs_bub  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ifid_stage #(
        .POST_NOPS (1)
    ) u_dut1 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .if_valid_i   (if_valid),
        .if_pc_i      (if_pc),
        .if_inst_i    (if_inst),
        .jump_stall_i (jump_stall),
        .full_stall_i (full_stall),
        .jump_en_i    (jump_en),
        .id_valid_o   (d_valid[0]),
        .id_pc_o      (d_pc[0]),
        .id_inst_o    (d_inst[0]),
        .id_bubble_o  (d_bubble[0])
`ifdef IFID_PERF_CNT_EN
        ,
        .perf_bubble_cnt_o (d_pbub[0]),
        .perf_hold_cnt_o   (d_phold[0])
`endif
    );

    ifid_stage #(
        .POST_NOPS (3)
    ) u_dut3 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .if_valid_i   (if_valid),
        .if_pc_i      (if_pc),
        .if_inst_i    (if_inst),
        .jump_stall_i (jump_stall),
        .full_stall_i (full_stall),
        .jump_en_i    (jump_en),
        .id_valid_o   (d_valid[1]),
        .id_pc_o      (d_pc[1]),
        .id_inst_o    (d_inst[1]),
        .id_bubble_o  (d_bubble[1])
`ifdef IFID_PERF_CNT_EN
        ,
        .perf_bubble_cnt_o (d_pbub[1]),
        .perf_hold_cnt_o   (d_phold[1])
`endif
    );

    function automatic int post_nops(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]   = 0;
            m_stall[k]  = 1'b0;
            m_valid[k]  = 1'b0;
            m_bubble[k] = 1'b1;
            m_pc[k]     = 32'h0;
            m_inst[k]   = NOP;
            m_pbub[k]   = 0;
            m_phold[k]  = 0;
        end
    endtask

    task automatic model_bubble(input int k);
        m_valid[k]  = 1'b0;
        m_bubble[k] = 1'b1;
        m_pc[k]     = 32'h0;
        m_inst[k]   = NOP;
        m_pbub[k]++;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input int k);
        if (jump_en) begin
            model_bubble(k);
            m_stall[k] = 1'b0;
            m_pend[k]  = post_nops(k) - 1;
        end else if (full_stall) begin
            m_phold[k]++;
        end else if (jump_stall) begin
            model_bubble(k);
            m_stall[k] = 1'b1;
            m_pend[k]  = 0;
        end else if (m_stall[k]) begin
            model_bubble(k);
            m_stall[k] = 1'b0;
            m_pend[k]  = post_nops(k) - 1;
        end else if (m_pend[k] > 0) begin
            model_bubble(k);
            m_pend[k]--;
        end else begin
            m_valid[k]  = if_valid;
            m_bubble[k] = 1'b0;
            m_pc[k]     = if_pc;
            m_inst[k]   = if_valid ? if_inst : NOP;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("valid[P%0d]", post_nops(k)), 32'(d_valid[k]), 32'(m_valid[k]));
            check_eq($sformatf("bubble[P%0d]", post_nops(k)), 32'(d_bubble[k]),
                     32'(m_bubble[k]));
            check_eq($sformatf("pc[P%0d]", post_nops(k)), d_pc[k], m_pc[k]);
            check_eq($sformatf("inst[P%0d]", post_nops(k)), d_inst[k], m_inst[k]);
`ifdef IFID_PERF_CNT_EN
            check_eq($sformatf("perf_bubble[P%0d]", post_nops(k)), d_pbub[k], 32'(m_pbub[k]));
            check_eq($sformatf("perf_hold[P%0d]", post_nops(k)), d_phold[k], 32'(m_phold[k]));
`endif
        end
    endtask

    // Advance one edge, update the model, sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        compare_all();
        for (int k = 0; k < 2; k++) obs_bub[k] += int'(d_bubble[k]);
    endtask

    // Assert reset between edges and check it takes effect without a clock.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b1;
        if_valid   = 1'b0;
        if_pc      = 32'h0;
        if_inst    = 32'h0;
        jump_stall = 1'b0;
        full_stall = 1'b0;
        jump_en    = 1'b0;
        #1;
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Plain stream.
        for (int i = 0; i < 3; i++) begin
            if_valid = 1'b1;
            if_pc    = 32'h100 + 32'(4 * i);
            if_inst  = $urandom;
            step();
            check_eq("stream_pc", d_pc[0], 32'h100 + 32'(4 * i));
        end

        // Jump stall for 3 edges then release: 3 + POST_NOPS bubbles.
        obs_bub[0] = 0;
        obs_bub[1] = 0;
        jump_stall = 1'b1;
        repeat (3) step();
        jump_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if_pc   = 32'h180 + 32'(4 * i);
            if_inst = $urandom;
            step();
        end
        check_eq("jstall_bubbles_P1", 32'(obs_bub[0]), 32'd4);
        check_eq("jstall_bubbles_P3", 32'(obs_bub[1]), 32'd6);

        // Full stall holds a loaded word.
        if_pc   = 32'h200;
        if_inst = $urandom;
        step();
        full_stall = 1'b1;
        if_pc      = 32'h204;
        repeat (2) step();
        check_eq("hold_pc", d_pc[0], 32'h200);
        check_eq("hold_valid", 32'(d_valid[0]), 32'd1);
        full_stall = 1'b0;

        // Full stall in the middle of a drain.
        jump_stall = 1'b1;
        step();
        jump_stall = 1'b0;
        step();
        full_stall = 1'b1;
        repeat (2) step();
        full_stall = 1'b0;
        repeat (4) step();

        // Flush while frozen by a full stall.
        if_pc = 32'h300;
        step();
        full_stall = 1'b1;
        step();
        jump_en = 1'b1;
        step();
        check_eq("flush_bubble", 32'(d_bubble[1]), 32'd1);
        jump_en    = 1'b0;
        full_stall = 1'b0;
        repeat (4) step();

        // Reset in the middle of a jump stall.
        jump_stall = 1'b1;
        repeat (2) step();
        async_reset();
        jump_stall = 1'b0;
        repeat (2) step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if_valid = ($urandom_range(0, 9) != 0);
            if_pc    = $urandom & 32'hFFFF_FFFC;
            if_inst  = $urandom;
            if ($urandom_range(0, 4) == 0) jump_stall = ~jump_stall;
            full_stall = ($urandom_range(0, 6) == 0);
            jump_en    = ($urandom_range(0, 19) == 0);
            step();
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
